// File: rtl/ssemi_adc_multichannel_cic_decimator.sv
// Time-multiplexed N-stage CIC decimator with per-channel state and a FWFT output FIFO.
// Define SSEMI_CIC_DECIM_ROUND_EN to round half up in the normalising right shift.
module ssemi_adc_multichannel_cic_decimator #(
  parameter int NUM_CHANNELS   = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int OUT_WIDTH      = 24,
  parameter int CIC_STAGES     = 4,
  parameter int MAX_DECIM_LOG2 = 6,
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int ACC_W = DATA_WIDTH + CIC_STAGES*MAX_DECIM_LOG2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [3:0]            i_decim_log2,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [CH_W-1:0]       i_channel,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [OUT_WIDTH-1:0]  o_data,
  output logic [CH_W-1:0]       o_channel,
  output logic                  o_busy,
  output logic                  o_error,
  input  logic                  i_clear_error
);

  localparam int DEPTH    = 2*NUM_CHANNELS;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH+1);
  localparam int FR_W     = MAX_DECIM_LOG2;
  localparam int SH_W     = ACC_W + OUT_WIDTH + 1;
  localparam int GAIN_ADJ = OUT_WIDTH - DATA_WIDTH;

  logic [3:0]              k_r;
  logic [CH_W-1:0]         exp_ch;
  logic [FR_W-1:0]         fr_cnt;
  logic signed [ACC_W-1:0] integ [NUM_CHANNELS][CIC_STAGES];
  logic signed [ACC_W-1:0] dly   [NUM_CHANNELS][CIC_STAGES];
  logic signed [ACC_W-1:0] integ_nxt [CIC_STAGES];
  logic signed [ACC_W-1:0] comb_y [CIC_STAGES+1];
  logic [ACC_W-1:0]        x_ext;

  logic accept, good, bad, last_ch, last_fr, push, pop;

  assign accept  = i_valid && o_ready;
  assign good    = accept && (i_channel == exp_ch);
  assign bad     = accept && (i_channel != exp_ch);
  assign last_ch = (exp_ch == CH_W'(NUM_CHANNELS-1));
  assign last_fr = (fr_cnt == FR_W'((1 << k_r) - 1));
  assign push    = good && i_enable && last_fr;
  assign pop     = o_valid && i_ready;
  assign x_ext   = {{(ACC_W-DATA_WIDTH){i_data[DATA_WIDTH-1]}}, i_data};

  // Only the expected channel's state is ever touched, so the datapath indexes by exp_ch.
  always_comb begin
    integ_nxt[0] = integ[exp_ch][0] + x_ext;
    for (int s = 1; s < CIC_STAGES; s++)
      integ_nxt[s] = integ[exp_ch][s] + integ_nxt[s-1];
    comb_y[0] = integ_nxt[CIC_STAGES-1];
    for (int s = 0; s < CIC_STAGES; s++)
      comb_y[s+1] = comb_y[s] - dly[exp_ch][s];
  end

  int                     sh;
  logic signed [SH_W-1:0] y_ext;
  logic [OUT_WIDTH-1:0]   norm_data;

  always_comb begin
    sh        = CIC_STAGES * int'(k_r) - GAIN_ADJ;
    y_ext     = SH_W'(comb_y[CIC_STAGES]);
    norm_data = '0;
    if (sh >= 0) begin
`ifdef SSEMI_CIC_DECIM_ROUND_EN
      if (sh > 0) y_ext = y_ext + (SH_W'(1) << (sh - 1));
`endif
      norm_data = OUT_WIDTH'(y_ext >>> sh);
    end else begin
      norm_data = OUT_WIDTH'(y_ext <<< (-sh));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      exp_ch <= '0;
      fr_cnt <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        for (int s = 0; s < CIC_STAGES; s++) begin
          integ[c][s] <= '0;
          dly[c][s]   <= '0;
        end
      end
    end else if (good) begin
      exp_ch <= last_ch ? '0 : exp_ch + 1'b1;
      if (last_ch) fr_cnt <= last_fr ? '0 : fr_cnt + 1'b1;
      for (int s = 0; s < CIC_STAGES; s++) begin
        integ[exp_ch][s] <= integ_nxt[s];
        if (last_fr) dly[exp_ch][s] <= comb_y[s];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      k_r <= 4'd1;
    end else if (!i_enable) begin
      if (i_decim_log2 == 4'd0)                         k_r <= 4'd1;
      else if (i_decim_log2 > 4'(MAX_DECIM_LOG2))       k_r <= 4'(MAX_DECIM_LOG2);
      else                                              k_r <= i_decim_log2;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)              o_error <= 1'b0;
    else if (bad)           o_error <= 1'b1;
    else if (i_clear_error) o_error <= 1'b0;
  end

  logic [OUT_WIDTH-1:0] mem_data [DEPTH];
  logic [CH_W-1:0]      mem_ch   [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count, count_nxt;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_data[wr_ptr] <= norm_data;
      mem_ch[wr_ptr]   <= exp_ch;
    end
  end

  // o_ready/o_busy are registered from post-edge occupancy so a full FIFO never sees a push.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      o_ready <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      count <= count_nxt;
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      o_ready <= i_enable && (count_nxt != CNT_W'(DEPTH));
      o_busy  <= i_enable || (count_nxt != '0);
    end
  end

  assign o_valid   = (count != '0);
  assign o_data    = o_valid ? mem_data[rd_ptr] : '0;
  assign o_channel = o_valid ? mem_ch[rd_ptr]   : '0;

endmodule

// File: doc/ssemi_adc_multichannel_cic_decimator.md
# ssemi_adc_multichannel_cic_decimator

Parametrised, time-multiplexed multi-channel CIC decimator. It is the next generation of the single-channel decimator front end. It accepts interleaved per-channel ADC samples on one valid/ready stream and runs an N-stage CIC per channel with a runtime power-of-two decimation ratio. Gain-normalised results are buffered in an output FIFO with backpressure. It sits between the ADC sample interface and the downstream FIR/halfband stages.

## Interface
Parameters:
- NUM_CHANNELS, 4, interleaved channels (≥1); CH_W = max(1, clog2(NUM_CHANNELS))
- DATA_WIDTH, 16, signed input width
- OUT_WIDTH, 24, signed output width (≥ DATA_WIDTH)
- CIC_STAGES, 4, integrator/comb stage count N
- MAX_DECIM_LOG2, 6, maximum log2 of the decimation ratio; ACC_W = DATA_WIDTH + CIC_STAGES*MAX_DECIM_LOG2

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_enable  in  1  run; low clears filter state and reloads the ratio
- i_decim_log2  in  4  requested log2 decimation ratio k
- i_valid  in  1  input sample valid
- o_ready  out  1  input can be accepted
- i_channel  in  CH_W  channel tag of the input sample
- i_data  in  DATA_WIDTH  signed input sample
- o_valid  out  1  FIFO head valid
- i_ready  in  1  downstream accepts head
- o_data  out  OUT_WIDTH  signed decimated sample
- o_channel  out  CH_W  channel tag of o_data
- o_busy  out  1  i_enable or FIFO non-empty
- o_error  out  1  sticky channel-sequence error
- i_clear_error  in  1  clears o_error

## Operation
- Ratio register k_r: loads clamp(i_decim_log2, 1, MAX_DECIM_LOG2) every cycle that i_enable=0. It holds while enabled. R = 2^k_r.
- Sequencing: the expected channel counter exp_ch steps 0..NUM_CHANNELS-1 and wraps. The frame counter fr_cnt steps 0..R-1 at each exp_ch wrap.
- Accept = i_valid && o_ready.
  - If i_channel ≠ exp_ch: the sample is consumed and discarded, o_error is set, and counters and filter state are unchanged.
- Integrators (per channel c, on a good accept): I0 ← I0 + x, Is ← Is + Is-1(new). All values are ACC_W bits, wrap modulo 2^ACC_W, and no saturation is applied.
- Comb: runs only on a good accept with fr_cnt = R-1. y0 = I(N-1)(new). For each stage s: ys = ys-1 − Ds, then Ds ← ys-1. The comb output is yN.
- Normalise: sh = CIC_STAGES*k_r − (OUT_WIDTH−DATA_WIDTH).
  - sh ≥ 0: arithmetic right shift by sh.
  - sh < 0: left shift by −sh.
  - The result is truncated to OUT_WIDTH.
  - The result, with its channel tag, is pushed to the FIFO.
- Output FIFO: first-word-fall-through, depth 2*NUM_CHANNELS. Pop = o_valid && i_ready.
- o_ready = i_enable && !full. Push and pop in the same cycle are allowed.
- i_enable=0: integrators, comb delays, exp_ch and fr_cnt are cleared every cycle. The FIFO is retained and stays drainable.
- o_error clears on i_clear_error. If a new error occurs in the same cycle as i_clear_error, the set wins.

## Timing
- Reset (i_rst=1 at an edge) clears:
  - all filter state, counters and the FIFO
  - k_r = 1
  - outputs o_ready=0, o_valid=0, o_data=0, o_channel=0, o_busy=0, o_error=0
- Reset mid-operation discards FIFO contents.
- o_ready is registered from the state after the edge. It may rise the cycle after i_enable rises.
- Latency: a comb-frame accept at edge t drives o_valid=1 with its data after edge t if the FIFO was empty.
- Throughput: one input per cycle. The output rate is one sample per channel per R frames.
- When full, o_ready=0. A pop in that cycle re-asserts o_ready next cycle.
- o_data and o_channel hold while o_valid=1 and i_ready=0.

## Configuration
- SSEMI_CIC_DECIM_ROUND_EN defined: when sh > 0, 2^(sh−1) is added to yN before the shift (round half up).
- SSEMI_CIC_DECIM_ROUND_EN undefined: plain truncating arithmetic shift.
- When sh ≤ 0, behaviour is identical with or without the macro.

## Test plan
- Reset check: assert i_rst for 3 cycles with i_valid=1. Required: all outputs are 0, no accept, and o_busy=0.
- DC settle: defaults, k=1, constant 1000 on all 4 channels in order. Required:
  - one output per channel every 2 frames, with tags 0,1,2,3 repeating
  - the 5th output per channel onward equals 256000
- Channel error: send tag 2 when 1 is expected. Required:
  - o_error=1 next cycle
  - the next correct tag-1 sample is processed normally
  - i_clear_error clears o_error
- Backpressure: i_ready=0, k=1, stream 32 samples. Required:
  - o_ready falls once the FIFO holds 8 entries
  - no data loss after i_ready=1; the outputs drain in order
- Ratio reload: run with k=2, drop i_enable, set i_decim_log2=9, raise i_enable. Required:
  - state cleared
  - k_r=6 (clamped), so one output per channel every 64 frames
- Rounding: k=3 (sh=4), input that yields yN=24. Required: o_data=2 with the macro, 1 without.
